// File: rtl/layer5_port_ctrl_if.sv
// Producer/consumer request bus of the layer-5 port controller.
// master = requester side, slave = controller side.
interface layer5_port_ctrl_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 128
) ();
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_gnt, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_gnt, rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/layer5_port_ctrl.sv
// Frame buffer port controller: port A writes, port B reads, a valid bitmap gates reads
// of unwritten words, and an EMPTY/FILLING/FULL FSM tracks frame fill.
module layer5_port_ctrl #(
    parameter int unsigned DEPTH = 112,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 128
) (
    input  logic          CK,
    input  logic          rst,
    input  logic          clr,
    layer5_port_ctrl_if.slave bus,
    output logic          sram_OEA,
    output logic          sram_OEB,
    output logic          sram_WEAN,
    output logic          sram_WEBN,
    output logic [AW-1:0] sram_A,
    output logic [AW-1:0] sram_B,
    output logic [DW-1:0] sram_DIA,
    output logic [DW-1:0] sram_DIB,
    input  logic [DW-1:0] sram_DOB,
    output logic          full,
    output logic          frame_done,
    output logic          err,
    output logic [AW-1:0] wr_cnt
);

    localparam logic [AW:0]   DepthW = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] DepthC = AW'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull} state_e;

    state_e          state_q, state_d;
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   sram_a_q, sram_b_q;
    logic            err_q, frame_done_q, rd_valid_q;
    logic            wr_in_range, rd_in_range, wr_oor, rd_oor;
    logic            wr_gnt, rd_gnt, rd_hit, cnt_inc;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DepthW);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DepthW);
    assign wr_oor      = bus.wr_req && !wr_in_range;
    assign rd_oor      = bus.rd_req && !rd_in_range;

    assign wr_gnt = !rst && !clr && bus.wr_req && wr_in_range;
    assign rd_hit = rd_in_range && valid_q[bus.rd_addr];
    // Same-address write wins; the read retries next cycle and sees the new word.
    assign rd_gnt = !rst && !clr && bus.rd_req && rd_hit
                    && !(wr_gnt && (bus.wr_addr == bus.rd_addr));

    assign cnt_inc = wr_gnt && !valid_q[bus.wr_addr] && (cnt_q != DepthC);
    assign cnt_d   = cnt_q + {{(AW-1){1'b0}}, cnt_inc};

    always_ff @(posedge CK) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (cnt_inc) state_d = (cnt_d == DepthC) ? StFull : StFilling;
                end
                StFilling: begin
                    if (cnt_d == DepthC) state_d = StFull;
                end
                StFull:  state_d = StFull;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        full = (state_q == StFull);
    end

    always_ff @(posedge CK) begin
        if (rst || clr) begin
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_gnt) valid_q[bus.wr_addr] <= 1'b1;
            cnt_q <= cnt_d;
            err_q <= err_q | wr_oor | rd_oor;
        end
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sram_a_q     <= '0;
            sram_b_q     <= '0;
        end else begin
            rd_valid_q   <= rd_gnt;
            frame_done_q <= (state_d == StFull) && (state_q != StFull);
            if (wr_gnt) sram_a_q <= bus.wr_addr;
            if (rd_gnt) sram_b_q <= bus.rd_addr;
        end
    end

    assign bus.wr_gnt   = wr_gnt;
    assign bus.rd_gnt   = rd_gnt;
    // A reset aborts any read still in flight.
    assign bus.rd_valid = rd_valid_q && !rst;
    assign bus.rd_data  = (rd_valid_q && !rst) ? sram_DOB : '0;

    assign sram_OEA  = 1'b0;
    assign sram_WEBN = 1'b1;
    assign sram_DIB  = '0;
    assign sram_WEAN = !wr_gnt;
    assign sram_OEB  = rd_gnt;
    assign sram_A    = wr_gnt ? bus.wr_addr : sram_a_q;
    assign sram_B    = rd_gnt ? bus.rd_addr : sram_b_q;
    assign sram_DIA  = wr_gnt ? bus.wr_data : '0;

    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign wr_cnt     = cnt_q;

endmodule

// File: tb/tb_layer5_port_ctrl.sv
// Bench for layer5_port_ctrl: vector table, directed frame sequences and random traffic
// checked against a behavioural model of the frame buffer.
module tb_layer5_port_ctrl;
    localparam int DEPTH = 112;
    localparam int AW    = 7;
    localparam int DW    = 128;

    logic          CK = 1'b0;
    logic          rst, clr;
    logic          sram_OEA, sram_OEB, sram_WEAN, sram_WEBN;
    logic [AW-1:0] sram_A, sram_B;
    logic [DW-1:0] sram_DIA, sram_DIB;
    logic [DW-1:0] sram_DOB = '0;
    logic          full, frame_done, err;
    logic [AW-1:0] wr_cnt;

    layer5_port_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    layer5_port_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CK(CK), .rst(rst), .clr(clr), .bus(bus),
        .sram_OEA(sram_OEA), .sram_OEB(sram_OEB), .sram_WEAN(sram_WEAN),
        .sram_WEBN(sram_WEBN), .sram_A(sram_A), .sram_B(sram_B),
        .sram_DIA(sram_DIA), .sram_DIB(sram_DIB), .sram_DOB(sram_DOB),
        .full(full), .frame_done(frame_done), .err(err), .wr_cnt(wr_cnt)
    );

    always #5 CK = ~CK;

    // Dual-port SRAM stand-in: synchronous write on A, one-cycle read on B.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge CK) begin
        if (!sram_WEAN) mem[sram_A] <= sram_DIA;
        if (sram_OEB) sram_DOB <= mem[sram_B];
    end

    int tests = 0;
    int fails = 0;

    // Reference model of the frame buffer.
    bit            m_valid [DEPTH];
    logic [DW-1:0] m_data  [DEPTH];
    int            m_cnt, m_pend_addr, m_last_a, m_last_b;
    bit            m_err, m_pend, m_was_full, m_known;

    bit            c_rst, c_clr, c_wr, c_rd;
    int            c_wa, c_ra;
    logic [DW-1:0] c_wd;
    bit            e_wg, e_rg;

    typedef struct {
        bit clr; bit wr; int wa; bit rd; int ra;
        bit e_wg; bit e_rg; bit e_rv; bit e_err; int e_cnt;
    } vec_t;
    vec_t vecs [18];

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset_vars();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic model_check();
        bit full_now;
        e_wg = !c_rst && !c_clr && c_wr && (c_wa < DEPTH);
        e_rg = 1'b0;
        if (!c_rst && !c_clr && c_rd && (c_ra < DEPTH))
            e_rg = m_valid[c_ra] && !(e_wg && (c_wa == c_ra));
        chk1("wr_gnt", bus.wr_gnt, e_wg);
        chk1("rd_gnt", bus.rd_gnt, e_rg);
        chk1("sram_WEAN", sram_WEAN, !e_wg);
        chk1("sram_OEB", sram_OEB, e_rg);
        chk1("sram_OEA", sram_OEA, 1'b0);
        chk1("sram_WEBN", sram_WEBN, 1'b1);
        chkw("sram_DIB", sram_DIB, '0);
        chk1("no_collide", !sram_WEAN && sram_OEB && (sram_A == sram_B), 1'b0);
        chk1("rd_valid", bus.rd_valid, m_pend && !c_rst);
        chkw("rd_data", bus.rd_data, (m_pend && !c_rst) ? m_data[m_pend_addr] : '0);
        if (e_wg) chkw("sram_DIA", sram_DIA, c_wd);
        if (m_known) begin
            full_now = (m_cnt == DEPTH);
            chkn("sram_A", int'(sram_A), e_wg ? c_wa : m_last_a);
            chkn("sram_B", int'(sram_B), e_rg ? c_ra : m_last_b);
            chkn("wr_cnt", int'(wr_cnt), m_cnt);
            chk1("full", full, full_now);
            chk1("frame_done", frame_done, full_now && !m_was_full);
            chk1("err", err, m_err);
        end
    endtask

    task automatic model_step();
        if (c_rst) begin
            model_reset_vars();
            m_pend = 1'b0; m_was_full = 1'b0; m_last_a = 0; m_last_b = 0; m_known = 1'b1;
        end else begin
            m_was_full = (m_cnt == DEPTH);
            m_pend = e_rg; m_pend_addr = c_ra;
            if (e_wg) m_last_a = c_wa;
            if (e_rg) m_last_b = c_ra;
            if (c_clr) begin
                model_reset_vars();
            end else begin
                if (e_wg) begin
                    if (!m_valid[c_wa] && m_cnt < DEPTH) m_cnt++;
                    m_valid[c_wa] = 1'b1;
                    m_data[c_wa] = c_wd;
                end
                if ((c_wr && c_wa >= DEPTH) || (c_rd && c_ra >= DEPTH)) m_err = 1'b1;
            end
        end
    endtask

    task automatic cyc_pre(input bit r, input bit c, input bit wr, input int wa,
                           input bit rd, input int ra);
        c_rst = r; c_clr = c; c_wr = wr; c_wa = wa; c_rd = rd; c_ra = ra;
        c_wd = rand_word();
        rst = r; clr = c;
        bus.wr_req = wr; bus.wr_addr = AW'(wa); bus.wr_data = c_wd;
        bus.rd_req = rd; bus.rd_addr = AW'(ra);
        #4;
        model_check();
    endtask

    task automatic cyc_post();
        @(posedge CK);
        model_step();
        #1;
    endtask

    task automatic cyc(input bit r, input bit c, input bit wr, input int wa,
                       input bit rd, input int ra);
        cyc_pre(r, c, wr, wa, rd, ra);
        cyc_post();
    endtask

    int ra_r, wa_r, pick;

    initial begin
        m_known = 1'b0; m_pend = 1'b0; m_was_full = 1'b0;
        m_cnt = 0; m_err = 1'b0; m_last_a = 0; m_last_b = 0; m_pend_addr = 0;

        //                clr wr  wa   rd  ra   wg rg rv err cnt
        vecs[0]  = '{1'b0, 1'b0,   0, 1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1,   5, 1'b1,   5, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0,   0, 1'b1,   5, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0,   0, 1'b0,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{1'b0, 1'b1,   3, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b0, 1'b1,   3, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 1'b1,   9, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b0, 1'b1,   9, 1'b1,   9, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[8]  = '{1'b0, 1'b0,   0, 1'b1,   9, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b0, 1'b0,   0, 1'b0,   0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[10] = '{1'b0, 1'b1, 112, 1'b0,   0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b0,   0, 1'b1, 127, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[12] = '{1'b0, 1'b1,   0, 1'b1,   3, 1'b1, 1'b1, 1'b0, 1'b1, 3};
        vecs[13] = '{1'b1, 1'b1,   1, 1'b1,   3, 1'b0, 1'b0, 1'b1, 1'b1, 4};
        vecs[14] = '{1'b0, 1'b0,   0, 1'b1,   3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[15] = '{1'b0, 1'b1,   3, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[16] = '{1'b0, 1'b1,   3, 1'b0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{1'b0, 1'b0,   0, 1'b0,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

        // Reset, then check the documented reset values while still in reset.
        cyc(1, 0, 0, 0, 0, 0);
        cyc_pre(1, 1, 1, 4, 1, 4);
        chkn("rst_cnt", int'(wr_cnt), 0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkn("rst_sram_A", int'(sram_A), 0);
        chkn("rst_sram_B", int'(sram_B), 0);
        cyc_post();

        foreach (vecs[i]) begin
            cyc_pre(0, vecs[i].clr, vecs[i].wr, vecs[i].wa, vecs[i].rd, vecs[i].ra);
            chk1($sformatf("vec%0d_wg", i), bus.wr_gnt, vecs[i].e_wg);
            chk1($sformatf("vec%0d_rg", i), bus.rd_gnt, vecs[i].e_rg);
            chk1($sformatf("vec%0d_rv", i), bus.rd_valid, vecs[i].e_rv);
            chk1($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            chkn($sformatf("vec%0d_cnt", i), int'(wr_cnt), vecs[i].e_cnt);
            cyc_post();
        end
        chk1("rewrite_not_full", full, 1'b0);

        // Fill a whole frame back-to-back.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc_pre(0, 0, 1, i, 0, 0);
            chkn("fill_cnt", int'(wr_cnt), i);
            chk1("fill_full", full, 1'b0);
            cyc_post();
        end
        cyc_pre(0, 0, 0, 0, 0, 0);
        chkn("full_cnt", int'(wr_cnt), DEPTH);
        chk1("full_flag", full, 1'b1);
        chk1("frame_done_1", frame_done, 1'b1);
        cyc_post();
        cyc_pre(0, 0, 1, 4, 1, 5);
        chk1("frame_done_0", frame_done, 1'b0);
        chk1("full_wr_gnt", bus.wr_gnt, 1'b1);
        chk1("full_rd_gnt", bus.rd_gnt, 1'b1);
        cyc_post();
        cyc_pre(0, 0, 0, 0, 1, 0);
        chkn("full_rewrite_cnt", int'(wr_cnt), DEPTH);
        chk1("full_still", full, 1'b1);
        cyc_post();

        // clr in FULL with a read pending.
        cyc_pre(0, 1, 1, 2, 1, 0);
        chk1("clr_rd_gnt", bus.rd_gnt, 1'b0);
        chk1("clr_wr_gnt", bus.wr_gnt, 1'b0);
        chk1("clr_rv_kept", bus.rd_valid, 1'b1);
        cyc_post();
        cyc_pre(0, 0, 0, 0, 1, 0);
        chk1("post_clr_rd_gnt", bus.rd_gnt, 1'b0);
        chkn("post_clr_cnt", int'(wr_cnt), 0);
        chk1("post_clr_full", full, 1'b0);
        cyc_post();

        // Reset with a read in flight: no rd_valid afterwards.
        cyc(0, 0, 1, 7, 0, 0);
        cyc_pre(0, 0, 0, 0, 1, 7);
        chk1("pre_rst_rd_gnt", bus.rd_gnt, 1'b1);
        cyc_post();
        cyc_pre(1, 0, 0, 0, 0, 0);
        chk1("rst_rv_drop", bus.rd_valid, 1'b0);
        cyc_post();
        cyc_pre(0, 0, 0, 0, 0, 0);
        chk1("post_rst_rv", bus.rd_valid, 1'b0);
        chkn("post_rst_cnt", int'(wr_cnt), 0);
        cyc_post();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 99));
            wa_r = (pick < 70) ? int'($urandom_range(0, 15)) :
                   (pick < 95) ? int'($urandom_range(0, DEPTH - 1)) :
                                 int'($urandom_range(DEPTH, 127));
            pick = int'($urandom_range(0, 99));
            ra_r = (pick < 75) ? int'($urandom_range(0, 15)) :
                   (pick < 97) ? int'($urandom_range(0, DEPTH - 1)) :
                                 int'($urandom_range(DEPTH, 127));
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 2) != 0), wa_r, ($urandom_range(0, 2) != 0), ra_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
